bsg_decode_accum: RTL



---
 rtl/bsg_decode_accum_if.sv | 29 ++
 rtl/bsg_decode_accum.sv | 110 +++++++++++
 2 files changed

// File: rtl/bsg_decode_accum_if.sv
// Handshake bundle for bsg_decode_accum.
//   Index side  (ready/valid): v_i, addr_i, last_i -> block; ready_o <- block.
//   Result side (valid/yumi) : v_o, mask_o, count_o, err_o <- block; yumi_i -> block.
// master: the environment driving indices and consuming results.
// slave : the accumulator itself.
interface bsg_decode_accum_if #(
  parameter int unsigned width_p    = 16,
  parameter int unsigned lg_width_p = $clog2(width_p)
);
  logic                  v_i;
  logic [lg_width_p-1:0] addr_i;
  logic                  last_i;
  logic                  ready_o;
  logic                  v_o;
  logic [width_p-1:0]    mask_o;
  logic [lg_width_p:0]   count_o;
  logic [1:0]            err_o;
  logic                  yumi_i;

  modport master (
    output v_i, addr_i, last_i, yumi_i,
    input  ready_o, v_o, mask_o, count_o, err_o
  );

  modport slave (
    input  v_i, addr_i, last_i, yumi_i,
    output ready_o, v_o, mask_o, count_o, err_o
  );
endinterface

// File: rtl/bsg_decode_accum.sv
// bsg_decode_accum: rebuilds a width_p-wide bit mask from a stream of bit
// indices. Each accepted index sets its mask bit; a beat flagged last closes
// the packet and the mask, its population count and error flags are offered
// downstream until the consumer yumis them.
// Ports:
//   clk_i      clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   bus        bsg_decode_accum_if slave modport
//     v_i/addr_i/last_i/ready_o  index stream (ready/valid)
//     v_o/mask_o/count_o/err_o/yumi_i  packet result (valid/yumi)
//     err_o[0] duplicate index seen, err_o[1] out-of-range index seen
module bsg_decode_accum #(
  parameter int unsigned width_p    = 16,
  parameter int unsigned lg_width_p = $clog2(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  bsg_decode_accum_if.slave  bus
);

  localparam int unsigned count_w_lp = lg_width_p + 1;
  localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

  typedef enum logic {
    ACCUM_S = 1'b0,
    HOLD_S  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [width_p-1:0]    mask_q, mask_d;
  logic [count_w_lp-1:0] count_q, count_d;
  logic [1:0]            err_q, err_d;

  logic [width_p-1:0]    dec;
  logic                  hit;
  logic                  oor;
  logic                  accept;

  // One-hot of the incoming index; an out-of-range index shifts to all zero.
  assign dec    = one_lp << bus.addr_i;
  assign hit    = |(mask_q & dec);
  assign accept = bus.v_i && (state_q == ACCUM_S);

  // Out-of-range indices exist only when width_p is not a power of two.
  if ((1 << lg_width_p) == width_p) begin : g_pow2
    assign oor = 1'b0;
  end else begin : g_npow2
    assign oor = ({1'b0, bus.addr_i} >= count_w_lp'(width_p));
  end

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      ACCUM_S: begin
        if (accept) begin
          if (oor) begin
            err_d[1] = 1'b1;
          end else if (hit) begin
            err_d[0] = 1'b1;
          end else begin
            mask_d  = mask_q | dec;
            count_d = count_q + count_w_lp'(1);
          end
          if (bus.last_i) begin
            state_d = HOLD_S;
          end
        end
      end
      HOLD_S: begin
        // Result is consumed and the accumulator is emptied on the same edge.
        if (bus.yumi_i) begin
          state_d = ACCUM_S;
          mask_d  = '0;
          count_d = '0;
          err_d   = '0;
        end
      end
      default: begin
        state_d = ACCUM_S;
      end
    endcase
  end

  // State and accumulator registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ACCUM_S;
      mask_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.ready_o = (state_q == ACCUM_S);
  assign bus.v_o     = (state_q == HOLD_S);
  assign bus.mask_o  = mask_q;
  assign bus.count_o = count_q;
  assign bus.err_o   = err_q;

endmodule
